bcd4_adder: RTL and testbench

//  Registered N-digit packed-BCD adder with carry-in and carry-out. Default is 4 digits: 16-bit operands, 17-bit result.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_add.sv | 31 +++
 rtl/bcd4_adder.sv | 114 +++++++++++
 tb/tb_bcd4_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decimal limits and a digit validity helper.
// No ports; imported by bcd_digit_add and bcd4_adder.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  // True when the nibble is a legal decimal digit 0..9.
  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with carry in/out.
// Ports:
//   a_i, b_i : BCD digits (non-BCD values accepted, corrected by the same rule)
//   c_i      : carry from the next-lower digit
//   digit    : decimal result digit
//   c_out    : decimal carry to the next-higher digit
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       c_i,
  output bcd_digit_t digit,
  output logic       c_out
);

  logic [BCD_W:0] t;

  // Binary sum, then +6 correction when it leaves the decimal range.
  // The 4-bit add wraps, giving (t + 6) mod 16.
  always_comb begin
    t     = (BCD_W+1)'(a_i) + (BCD_W+1)'(b_i) + (BCD_W+1)'(c_i);
    digit = t[BCD_W-1:0];
    c_out = 1'b0;
    if (t > (BCD_W+1)'(BCD_MAX)) begin
      digit = t[BCD_W-1:0] + BCD_CORR;
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd4_adder.sv
// Registered N-digit packed-BCD adder with carry-in and decimal carry-out.
// Arithmetic core of the serial BCD ALU; subtraction is done by the caller
// supplying the 9's complement of A.
// Optional feature macro: BCD4_ADDER_INVALID_FLAG_EN adds the registered
// output err, set when any operand digit on a valid input exceeds 9.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   in_valid  : operands and cin valid this cycle
//   cin       : carry into the least-significant digit
//   a, b      : packed BCD operands, digit i at [4i+3:4i]
//   sum       : registered result, MSB is the decimal carry-out
//   out_valid : sum was updated on this edge from a valid input
//   err       : (macro only) registered non-BCD operand flag
module bcd4_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS:0]     sum,
`ifdef BCD4_ADDER_INVALID_FLAG_EN
  output logic                  out_valid,
  output logic                  err
`else
  output logic                  out_valid
`endif
);

  localparam int unsigned OP_W  = BCD_W * DIGITS;
  localparam int unsigned SUM_W = OP_W + 1;

  logic [DIGITS:0]  carry;
  logic [OP_W-1:0]  digits;
  logic [SUM_W-1:0] sum_calc;

  logic [SUM_W-1:0] sum_d,       sum_q;
  logic             out_valid_d, out_valid_q;

  // Ripple chain of digit adders, least-significant digit first.
  assign carry[0] = cin;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_digit_add u_digit (
      .a_i   (a[BCD_W*i +: BCD_W]),
      .b_i   (b[BCD_W*i +: BCD_W]),
      .c_i   (carry[i]),
      .digit (digits[BCD_W*i +: BCD_W]),
      .c_out (carry[i+1])
    );
  end

  assign sum_calc = {carry[DIGITS], digits};

  // Next state: capture on valid input, otherwise hold the result.
  always_comb begin
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_calc;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;

`ifdef BCD4_ADDER_INVALID_FLAG_EN
  logic bad_digit;
  logic err_d, err_q;

  // Any nibble of either operand outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[BCD_W*i +: BCD_W]) || !is_bcd(b[BCD_W*i +: BCD_W])) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (in_valid) begin
      err_d = bad_digit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_bcd4_adder.sv
// Scoreboard bench for bcd4_adder: expected results are queued when an
// operand pair is driven and compared one cycle later when the DUT reports.
module tb_bcd4_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned OP_W   = 4 * DIGITS;
  localparam int unsigned SUM_W  = OP_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             cin = 1'b0;
  logic [OP_W-1:0]  a = '0;
  logic [OP_W-1:0]  b = '0;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
`ifdef BCD4_ADDER_INVALID_FLAG_EN
  logic             err;
`endif

  typedef struct {
    logic [SUM_W-1:0] sum;
    logic             err;
    string            tag;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [SUM_W-1:0] last_sum = '0;
  logic             last_err = 1'b0;
  bit               mon_en   = 1'b0;

  bcd4_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .sum       (sum),
`ifdef BCD4_ADDER_INVALID_FLAG_EN
    .out_valid (out_valid),
    .err       (err)
`else
    .out_valid (out_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [OP_W-1:0] v);
    int r = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [SUM_W-1:0] int_to_bcd(input int n);
    logic [SUM_W-1:0] r;
    int m;
    r = '0;
    r[SUM_W-1] = (n >= 10000);
    m = n % 10000;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
    logic bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Drive one operand pair with an explicit expected sum.
  task automatic send_exp(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv,
                          input logic ci, input logic [SUM_W-1:0] es, input string tag);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    e.sum = es;
    e.err = has_bad(av, bv);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Drive a legal BCD pair; expectation from decimal arithmetic.
  task automatic send_bcd(input logic [OP_W-1:0] av, input logic [OP_W-1:0] bv,
                          input logic ci, input string tag);
    send_exp(av, bv, ci, int_to_bcd(bcd_to_int(av) + bcd_to_int(bv) + int'(ci)), tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Output monitor: valid results pop the scoreboard, idle cycles must hold.
  always @(posedge clk) begin
    #1;
    if (mon_en && !rst) begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq({mon_e.tag, "_valid"}, 32'(out_valid), 32'(1'b1));
        check_eq({mon_e.tag, "_sum"}, 32'(sum), 32'(mon_e.sum));
`ifdef BCD4_ADDER_INVALID_FLAG_EN
        check_eq({mon_e.tag, "_err"}, 32'(err), 32'(mon_e.err));
`endif
        last_sum = mon_e.sum;
        last_err = mon_e.err;
      end else begin
        check_eq("idle_valid", 32'(out_valid), 32'(1'b0));
        check_eq("idle_sum", 32'(sum), 32'(last_sum));
`ifdef BCD4_ADDER_INVALID_FLAG_EN
        check_eq("idle_err", 32'(err), 32'(last_err));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SUM_W-1:0] ra, rb;

    #1;
    check_eq("reset_sum", 32'(sum), 32'(0));
    check_eq("reset_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    send_exp(16'h2379, 16'h1591, 1'b0, 17'h0_3970, "add_2379_1591");
    send_exp(16'h7620, 16'h1591, 1'b0, 17'h0_9211, "sub_2379_1591");
    send_exp(16'h9999, 16'h0001, 1'b0, 17'h1_0000, "wrap_9999_1");
    send_exp(16'h9999, 16'h9999, 1'b1, 17'h1_9999, "max_cin");
    send_exp(16'h0999, 16'h0000, 1'b1, 17'h0_1000, "ripple3");
    idle(2);
    send_exp(16'h0000, 16'h0000, 1'b0, 17'h0_0000, "zero");
    send_exp(16'h0000, 16'h0000, 1'b1, 17'h0_0001, "cin_only");
    send_exp(16'h5000, 16'h5000, 1'b0, 17'h1_0000, "msd_carry");
    // Non-BCD digit: A+0 -> 16 mod 16 = 0, carry into hundreds.
    send_exp(16'h00A0, 16'h0000, 1'b0, 17'h0_0100, "nonbcd_00A0");
    send_exp(16'h0090, 16'h0000, 1'b0, 17'h0_0090, "bcd_0090");
    idle(1);

    for (int i = 0; i < 24; i++) begin
      ra = int_to_bcd(int'($urandom_range(0, 9999)));
      rb = int_to_bcd(int'($urandom_range(0, 9999)));
      send_bcd(ra[OP_W-1:0], rb[OP_W-1:0], 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Reset in the middle of an in-flight operation clears outputs at once.
    send_exp(16'h1234, 16'h4321, 1'b0, 17'h0_5555, "pre_reset");
    send_exp(16'h1111, 16'h2222, 1'b0, 17'h0_3333, "inflight");
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    void'(sb_q.pop_back());
    last_sum = '0;
    last_err = 1'b0;
    #1;
    check_eq("async_rst_sum", 32'(sum), 32'(0));
    check_eq("async_rst_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    send_bcd(16'h4567, 16'h5432, 1'b1, "post_reset");
    idle(2);
    check_eq("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
